// File: rtl/ws2812_pkg.sv
// Shared widths and encodings for the ws2812 write scheduler slice.
package ws2812_pkg;
  localparam int LED_IDX_W = 8;
  localparam int RGB_W     = 24;

  typedef enum logic {HOST = 1'b0, FILL = 1'b1} grant_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fill_state_e;
endpackage

// File: rtl/ws2812_fill_engine.sv
// Range-fill sequencer: latches a validated range and colour, steps cur on each grant.
module ws2812_fill_engine
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_start,
  input  logic [LED_IDX_W-1:0] fill_first,
  input  logic [LED_IDX_W-1:0] fill_last,
  input  logic [RGB_W-1:0]     fill_rgb,
  input  logic                 grant,
  output logic                 busy,
  output logic [LED_IDX_W-1:0] cur,
  output logic [RGB_W-1:0]     colour,
  output logic                 last_hit,
  output logic                 start_err
);
  localparam logic [LED_IDX_W:0] LED_CNT = (LED_IDX_W+1)'(NUM_LEDS);

  fill_state_e          state_q, state_d;
  logic [LED_IDX_W-1:0] cur_q, cur_d, last_q, last_d;
  logic [RGB_W-1:0]     colour_q, colour_d;
  logic                 range_bad;

  assign range_bad = (fill_first > fill_last) || ({1'b0, fill_last} >= LED_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: if (fill_start && !range_bad) begin
        state_d  = RUN;
        cur_d    = fill_first;
        last_d   = fill_last;
        colour_d = fill_rgb;
      end
      RUN: if (grant) begin
        if (cur_q == last_q) state_d = IDLE;
        else                 cur_d   = cur_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // fill_start is only examined in IDLE, so a start while running is silently dropped
  always_comb begin
    busy      = (state_q == RUN);
    cur       = cur_q;
    colour    = colour_q;
    last_hit  = busy && grant && (cur_q == last_q);
    start_err = fill_start && !busy && range_bad;
  end
endmodule

// File: rtl/ws2812_write_scheduler.sv
// Arbitrates host single writes against the fill engine onto one registered driver write port.
module ws2812_write_scheduler
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [LED_IDX_W-1:0] host_led_num,
  input  logic [RGB_W-1:0]     host_rgb,
  input  logic                 fill_start,
  input  logic [LED_IDX_W-1:0] fill_first,
  input  logic [LED_IDX_W-1:0] fill_last,
  input  logic [RGB_W-1:0]     fill_rgb,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic                 err,
  output logic                 write,
  output logic [LED_IDX_W-1:0] led_num,
  output logic [RGB_W-1:0]     rgb_data
);
  localparam logic [LED_IDX_W:0] LED_CNT = (LED_IDX_W+1)'(NUM_LEDS);

  grant_e               last_grant_q, last_grant_d;
  logic                 write_q, write_d, fill_done_q, fill_done_d, err_q, err_d;
  logic [LED_IDX_W-1:0] led_num_q, led_num_d, fill_cur;
  logic [RGB_W-1:0]     rgb_q, rgb_d, fill_colour;
  logic                 host_acc, host_bad, grant_host, grant_fill, fill_last_hit, fill_start_err;

  ws2812_fill_engine #(.NUM_LEDS(NUM_LEDS)) u_fill (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_first (fill_first),
    .fill_last  (fill_last),
    .fill_rgb   (fill_rgb),
    .grant      (grant_fill),
    .busy       (fill_busy),
    .cur        (fill_cur),
    .colour     (fill_colour),
    .last_hit   (fill_last_hit),
    .start_err  (fill_start_err)
  );

  // Host is held off only on the fill's turn, which makes the round-robin tie-break
  // visible to the host without looking at host_valid.
  assign host_ready = !(fill_busy && last_grant_q == HOST);
  assign host_acc   = host_valid && host_ready;
  assign host_bad   = {1'b0, host_led_num} >= LED_CNT;
  assign grant_host = host_acc && (!fill_busy || last_grant_q == FILL);
  assign grant_fill = fill_busy && !grant_host;

  always_comb begin
    last_grant_d = last_grant_q;
    write_d      = 1'b0;
    led_num_d    = led_num_q;
    rgb_d        = rgb_q;
    if (grant_host) begin
      last_grant_d = HOST;
      if (!host_bad) begin
        write_d   = 1'b1;
        led_num_d = host_led_num;
        rgb_d     = host_rgb;
      end
    end else if (grant_fill) begin
      last_grant_d = FILL;
      write_d      = 1'b1;
      led_num_d    = fill_cur;
      rgb_d        = fill_colour;
    end
    fill_done_d = fill_last_hit;
    err_d       = (grant_host && host_bad) || fill_start_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= FILL;
      write_q      <= 1'b0;
      led_num_q    <= '0;
      rgb_q        <= '0;
      fill_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      led_num_q    <= led_num_d;
      rgb_q        <= rgb_d;
      fill_done_q  <= fill_done_d;
      err_q        <= err_d;
    end
  end

  assign write     = write_q;
  assign led_num   = led_num_q;
  assign rgb_data  = rgb_q;
  assign fill_done = fill_done_q;
  assign err       = err_q;
endmodule

// File: doc/ws2812_write_scheduler.md
WS2812_WRITE_SCHEDULER -- requirements
Module: ws2812_write_scheduler

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, the LED count of the attached ws2812 driver (1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port host_valid, input, 1, host single-write request.
REQ-005 SHALL have port host_ready, output, 1, host request accepted this cycle when high together with host_valid.
REQ-006 SHALL have port host_led_num, input, 8, host target LED index.
REQ-007 SHALL have port host_rgb, input, 24, host colour (GRB order as the driver expects).
REQ-008 SHALL have port fill_start, input, 1, one-cycle pulse starting a range fill.
REQ-009 SHALL have port fill_first, input, 8, first LED index of the fill, sampled on fill_start.
REQ-010 SHALL have port fill_last, input, 8, last LED index of the fill (inclusive), sampled on fill_start.
REQ-011 SHALL have port fill_rgb, input, 24, fill colour, sampled on fill_start.
REQ-012 SHALL have port fill_busy, output, 1, high while a fill is in progress.
REQ-013 SHALL have port fill_done, output, 1, one-cycle pulse after the last fill write is issued.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on a rejected request.
REQ-015 SHALL have ports write (output, 1), led_num (output, 8) and rgb_data (output, 24), all registered, driving the ws2812 driver write port directly.

Function
REQ-016 SHALL issue at most one driver write per cycle; write is high for exactly one cycle per granted request.
REQ-017 SHALL present write/led_num/rgb_data in the cycle after the grant (latency 1).
REQ-018 SHALL compute host_ready from internal state only (never from host_valid): host_ready = !(fill_busy && last_grant == HOST).
REQ-019 SHALL arbitrate round-robin: when both the host and the fill engine request, the grant goes to the requester not granted most recently; a lone requester is granted every cycle.
REQ-020 SHALL drop an accepted host request with host_led_num >= NUM_LEDS: no write, err pulsed the next cycle.
REQ-021 SHALL ignore fill_start while fill_busy is high (no err, registers unchanged).
REQ-022 SHALL reject a fill_start with fill_first > fill_last or fill_last >= NUM_LEDS: err pulsed next cycle, fill_busy stays low, no writes.
REQ-023 Fill FSM SHALL have states IDLE, RUN: IDLE->RUN on a valid fill_start (cur = fill_first, fill_busy high the next cycle); in RUN each grant writes LED cur with the latched colour; RUN->IDLE when the grant writes cur == fill_last, with fill_done pulsed in the same cycle that write is presented.
REQ-024 SHALL issue exactly fill_last - fill_first + 1 fill writes, in ascending index order.
REQ-025 SHALL accept a host transfer and a valid fill_start in the same cycle: the host write is issued first; fill writes follow from the next cycle.
REQ-026 SHALL allow the host to rewrite an LED inside an active fill range; the final value is the last write issued.

Reset
REQ-027 SHALL on reset drive write=0, led_num=0, rgb_data=0, fill_busy=0, fill_done=0, err=0, FSM=IDLE, last_grant=FILL (the host wins the first tie).
REQ-028 SHALL on reset during RUN abort the fill with no further writes and no fill_done; host_ready is high the cycle after reset deasserts.

Structure
REQ-029 Shared package ws2812_pkg SHALL hold the grant encoding (HOST, FILL), the fill FSM state encoding, and the LED_IDX_W=8 / RGB_W=24 width constants.
REQ-030 The fill FSM with its cur/last/colour registers SHALL be one sub-module, ws2812_fill_engine; arbitration and output registers stay in the top level.

Verification
REQ-031 Host-only: host write LED 3 = 0x00FF00 -> host_ready=1 and one write with led_num=3, rgb_data=0x00FF00 one cycle later.
REQ-032 Fill-only: fill 2..5 with 0x112233 -> writes to 2,3,4,5 on consecutive cycles; fill_done coincides with the led_num=5 write; fill_busy then drops.
REQ-033 Contention: fill 0..7 plus continuous host_valid to LED 1 -> grants alternate HOST/FILL starting with HOST; 8 fill writes over 16 cycles; host_ready low on every FILL-turn cycle.
REQ-034 Errors: host_led_num=8 (NUM_LEDS=8) -> err pulse, no write; fill 5..2 -> err pulse, fill_busy stays 0; fill 0..8 -> err pulse.
REQ-035 Reset mid-fill: fill 0..7, reset asserted after the 3rd write -> no further writes, no fill_done, all outputs at reset values.
REQ-036 fill_start while busy with a different range and colour -> ignored; the original fill completes unchanged.
